// File: rtl/regfile_wb_scheduler.sv
// Round-robin arbiter for the single register file write port, plus the
// pending-write scoreboard that stalls issue on RAW and WAW hazards.
module regfile_wb_scheduler #(
  parameter int register_width = 32,
  parameter int NUM_REQ = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic issue_valid,
  input  logic [4:0] issue_rd,
  input  logic issue_rd_en,
  input  logic [4:0] issue_rs1,
  input  logic [4:0] issue_rs2,
  input  logic [4:0] issue_rs3,
  input  logic [2:0] issue_rs_en,
  output logic issue_stall,
  input  logic [NUM_REQ-1:0] wb_valid,
  input  logic [5*NUM_REQ-1:0] wb_addr,
  input  logic [register_width*NUM_REQ-1:0] wb_data,
  output logic [NUM_REQ-1:0] wb_ready,
  output logic register_to_write_en,
  output logic [4:0] register_to_write_addr,
  output logic [register_width-1:0] register_to_write_data,
  output logic [31:0] pending,
  output logic wb_orphan
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] nxt_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic found;
  logic accept;
  logic [4:0] sel_addr;
  logic [register_width-1:0] sel_data;

  logic [2:0] rs_hit;
  logic waw;
  logic issue_fire;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic orphan_hit;

  // Offset k from rr_ptr is tried before offset k+1, so the first
  // valid requester at or after the pointer wins.
  always_comb begin
    gnt = '0;
    found = 1'b0;
    nxt_ptr = rr_ptr;
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && wb_valid[i] &&
            (i == (int'(rr_ptr) + k) % NUM_REQ)) begin
          found = 1'b1;
          gnt[i] = 1'b1;
          nxt_ptr = PW'((i + 1) % NUM_REQ);
          sel_addr = wb_addr[5*i +: 5];
          sel_data = wb_data[register_width*i +: register_width];
        end
      end
    end
  end

  assign wb_ready = resetn ? gnt : '0;
  assign accept = resetn && found;

  assign rs_hit[0] = issue_rs_en[0] && (issue_rs1 != 5'd0)
                     && pending[issue_rs1];
  assign rs_hit[1] = issue_rs_en[1] && (issue_rs2 != 5'd0)
                     && pending[issue_rs2];
  assign rs_hit[2] = issue_rs_en[2] && (issue_rs3 != 5'd0)
                     && pending[issue_rs3];
  assign waw = issue_rd_en && pending[issue_rd];

  assign issue_stall = issue_valid && ((|rs_hit) || waw);
  assign issue_fire = issue_valid && !issue_stall;

  assign set_mask = (issue_fire && issue_rd_en && (issue_rd != 5'd0))
                    ? (32'd1 << issue_rd) : 32'd0;
  assign clr_mask = register_to_write_en
                    ? (32'd1 << register_to_write_addr) : 32'd0;

  assign orphan_hit = accept && (sel_addr != 5'd0) && !pending[sel_addr];

  // Clear is applied before set so a new producer keeps its bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr <= '0;
      pending <= '0;
      wb_orphan <= 1'b0;
      register_to_write_en <= 1'b0;
      register_to_write_addr <= '0;
      register_to_write_data <= '0;
    end else begin
      pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;
      if (orphan_hit)
        wb_orphan <= 1'b1;
      register_to_write_en <= accept && (sel_addr != 5'd0);
      if (accept) begin
        rr_ptr <= nxt_ptr;
        register_to_write_addr <= sel_addr;
        register_to_write_data <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios plus random
// traffic, all checked against a cycle-level reference model.
module tb_regfile_wb_scheduler;

  localparam int W = 32;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  logic issue_valid;
  logic [4:0] issue_rd;
  logic issue_rd_en;
  logic [4:0] issue_rs1, issue_rs2, issue_rs3;
  logic [2:0] issue_rs_en;
  logic issue_stall;
  logic [N-1:0] wb_valid;
  logic [5*N-1:0] wb_addr;
  logic [W*N-1:0] wb_data;
  logic [N-1:0] wb_ready;
  logic register_to_write_en;
  logic [4:0] register_to_write_addr;
  logic [W-1:0] register_to_write_data;
  logic [31:0] pending;
  logic wb_orphan;

  regfile_wb_scheduler #(
    .register_width(W),
    .NUM_REQ(N)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .issue_rd_en(issue_rd_en),
    .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2),
    .issue_rs3(issue_rs3),
    .issue_rs_en(issue_rs_en),
    .issue_stall(issue_stall),
    .wb_valid(wb_valid),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .wb_ready(wb_ready),
    .register_to_write_en(register_to_write_en),
    .register_to_write_addr(register_to_write_addr),
    .register_to_write_data(register_to_write_data),
    .pending(pending),
    .wb_orphan(wb_orphan)
  );

  // Stand-in for register_file: stores whatever the write port commits.
  logic [31:0] rf [32] = '{default: 32'd0};
  always @(posedge clk)
    if (register_to_write_en)
      rf[register_to_write_addr] <= register_to_write_data;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  bit [31:0] m_pend;
  int m_ptr;
  bit m_en;
  bit [4:0] m_addr;
  bit [31:0] m_data;
  bit m_orph;
  int last_grant;
  int grants[$];
  int wq[N][$];
  bit [31:0] wd[N][$];

  task automatic model_reset();
    m_pend = '0; m_ptr = 0; m_en = 0;
    m_addr = '0; m_data = '0; m_orph = 0;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = '0; issue_rd_en = 0;
    issue_rs1 = '0; issue_rs2 = '0; issue_rs3 = '0;
    issue_rs_en = '0;
    wb_valid = '0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic issue(input int rd, input int rd_en, input int rs1,
                       input int rs2, input int rs3, input int rs_en);
    issue_valid = 1;
    issue_rd = 5'(rd);
    issue_rd_en = 1'(rd_en);
    issue_rs1 = 5'(rs1);
    issue_rs2 = 5'(rs2);
    issue_rs3 = 5'(rs3);
    issue_rs_en = 3'(rs_en);
  endtask

  task automatic set_wb(input int i, input int v, input int a,
                        input bit [31:0] d);
    wb_valid[i] = 1'(v);
    wb_addr[5*i +: 5] = 5'(a);
    wb_data[W*i +: W] = d;
  endtask

  task automatic post(input int i, input int a, input bit [31:0] d);
    wq[i].push_back(a);
    wd[i].push_back(d);
  endtask

  // One clock: compare every output with the model, then advance it.
  task automatic tick();
    int g, ci, nptr;
    bit es, ne, no;
    bit [N-1:0] er;
    bit [4:0] a, na;
    bit [31:0] np, nd;
    #2;
    es = issue_valid &&
         ((issue_rs_en[0] && m_pend[issue_rs1]) ||
          (issue_rs_en[1] && m_pend[issue_rs2]) ||
          (issue_rs_en[2] && m_pend[issue_rs3]) ||
          (issue_rd_en && m_pend[issue_rd]));
    g = -1;
    if (resetn)
      for (int k = 0; k < N; k++) begin
        ci = (m_ptr + k) % N;
        if (g < 0 && ((wb_valid >> ci) & 1) != 0) g = ci;
      end
    er = (g < 0) ? '0 : N'(1 << g);
    check("issue_stall", 32'(issue_stall), 32'(es));
    check("wb_ready", 32'(wb_ready), 32'(er));
    check("wr_en", 32'(register_to_write_en), 32'(m_en));
    check("wr_addr", 32'(register_to_write_addr), 32'(m_addr));
    check("wr_data", register_to_write_data, m_data);
    check("pending", pending, m_pend);
    check("wb_orphan", 32'(wb_orphan), 32'(m_orph));
    last_grant = g;
    np = m_pend; ne = 0; na = m_addr; nd = m_data;
    no = m_orph; nptr = m_ptr;
    if (!resetn) begin
      np = '0; na = '0; nd = '0; no = 0; nptr = 0;
    end else begin
      if (m_en) np[m_addr] = 0;
      if (issue_valid && !es && issue_rd_en && issue_rd != 0)
        np[issue_rd] = 1;
      if (g >= 0) begin
        a = 5'(wb_addr >> (5*g));
        if (a != 0 && !m_pend[a]) no = 1;
        ne = (a != 0);
        na = a;
        nd = 32'(wb_data >> (W*g));
        nptr = (g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    m_pend = np; m_en = ne; m_addr = na;
    m_data = nd; m_orph = no; m_ptr = nptr;
  endtask

  task automatic run_wb(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) begin
        if (wq[i].size() > 0) set_wb(i, 1, wq[i][0], wd[i][0]);
        else set_wb(i, 0, 0, 32'd0);
      end
      tick();
      if (last_grant >= 0) begin
        grants.push_back(last_grant);
        void'(wq[last_grant].pop_front());
        void'(wd[last_grant].pop_front());
      end
    end
    wb_valid = '0;
  endtask

  task automatic issue_seq(input int rd);
    issue(rd, 1, 0, 0, 0, 0);
    tick();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_rr[6];
    int exp_two[3];
    int ra;
    exp_rr = '{0, 1, 2, 0, 1, 2};
    exp_two = '{2, 0, 2};

    idle();
    resetn = 0;
    wb_valid = '1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("rst_ready", 32'(wb_ready), 32'd0);
      @(posedge clk);
    end
    #1;
    model_reset();
    resetn = 1;
    idle();
    check("rst_en", 32'(register_to_write_en), 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_orphan", 32'(wb_orphan), 32'd0);
    tick();

    // RAW on x5, resolved by requester 1
    issue_seq(5);
    issue(0, 0, 5, 0, 0, 3'b001);
    #1;
    check("raw_pend5", 32'(pending[5]), 32'd1);
    check("raw_stall", 32'(issue_stall), 32'd1);
    set_wb(1, 1, 5, 32'hDEADBEEF);
    tick();
    wb_valid = '0;
    check("raw_en", 32'(register_to_write_en), 32'd1);
    check("raw_addr", 32'(register_to_write_addr), 32'd5);
    #1;
    check("raw_stall_hold", 32'(issue_stall), 32'd1);
    tick();
    #1;
    check("raw_stall_drop", 32'(issue_stall), 32'd0);
    check("raw_rf5", rf[5], 32'hDEADBEEF);
    tick();
    idle();

    // Round robin with all three requesters
    for (int r = 10; r <= 16; r++) issue_seq(r);
    post(2, 16, 32'hA000_0010);
    run_wb(1);
    grants.delete();
    post(0, 10, 32'hA000_000A); post(0, 13, 32'hA000_000D);
    post(1, 11, 32'hA000_000B); post(1, 14, 32'hA000_000E);
    post(2, 12, 32'hA000_000C); post(2, 15, 32'hA000_000F);
    run_wb(6);
    check("rr_count", 32'(grants.size()), 32'd6);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      check("rr_grant", 32'(grants[i]), 32'(exp_rr[i]));

    // Requesters 0 and 2 only, starting from pointer 1
    for (int r = 17; r <= 20; r++) issue_seq(r);
    post(0, 17, 32'hA000_0011);
    run_wb(1);
    grants.delete();
    post(2, 18, 32'hA000_0012);
    post(0, 19, 32'hA000_0013);
    post(2, 20, 32'hA000_0014);
    run_wb(3);
    check("rr2_count", 32'(grants.size()), 32'd3);
    for (int i = 0; i < 3 && i < grants.size(); i++)
      check("rr2_grant", 32'(grants[i]), 32'(exp_two[i]));
    idle();
    tick();

    // Writeback to x0 is accepted and discarded
    set_wb(0, 1, 0, 32'h1111_1111);
    #1;
    check("x0_ready", 32'(wb_ready), 32'b001);
    tick();
    idle();
    check("x0_en", 32'(register_to_write_en), 32'd0);
    check("x0_orphan", 32'(wb_orphan), 32'd0);

    // Writeback to a register nobody is waiting on
    set_wb(2, 1, 9, 32'h1234_5678);
    tick();
    idle();
    check("x9_orphan", 32'(wb_orphan), 32'd1);
    check("x9_en", 32'(register_to_write_en), 32'd1);
    tick();
    check("x9_rf", rf[9], 32'h1234_5678);

    // Set and clear of x7 on the same edge
    set_wb(0, 1, 7, 32'h7777_7777);
    tick();
    idle();
    issue(7, 1, 0, 0, 0, 0);
    #1;
    check("se_stall", 32'(issue_stall), 32'd0);
    check("se_en", 32'(register_to_write_en), 32'd1);
    check("se_addr", 32'(register_to_write_addr), 32'd7);
    tick();
    idle();
    check("se_pend7", 32'(pending[7]), 32'd1);
    issue(0, 0, 0, 7, 0, 3'b010);
    #1;
    check("se_rs2_stall", 32'(issue_stall), 32'd1);
    tick();
    idle();

    // WAW on x3
    issue_seq(3);
    issue(3, 1, 0, 0, 0, 0);
    #1;
    check("waw_stall", 32'(issue_stall), 32'd1);
    tick();
    idle();
    post(0, 3, 32'h3333_3333);
    post(0, 7, 32'h7070_7070);
    run_wb(2);
    tick();
    check("clean_pending", pending, 32'd0);

    // Reset while x5/x8 pending and a requester is waiting
    issue_seq(5);
    issue_seq(8);
    check("mid_pending", pending, 32'h0000_0120);
    resetn = 0;
    set_wb(0, 1, 8, 32'hCAFE_F00D);
    issue(9, 1, 0, 0, 0, 0);
    tick();
    resetn = 1;
    idle();
    check("mid_rst_pending", pending, 32'd0);
    check("mid_rst_en", 32'(register_to_write_en), 32'd0);
    check("mid_rst_orphan", 32'(wb_orphan), 32'd0);
    tick();
    check("mid_rst_rf8", rf[8], 32'd0);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      resetn = ($urandom_range(0, 99) != 0);
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd = 5'($urandom);
      issue_rd_en = 1'($urandom_range(0, 1));
      issue_rs1 = 5'($urandom);
      issue_rs2 = 5'($urandom);
      issue_rs3 = 5'($urandom);
      issue_rs_en = 3'($urandom);
      for (int i = 0; i < N; i++)
        if (wq[i].size() == 0 && $urandom_range(0, 2) == 0) begin
          ra = $urandom_range(1, 31);
          for (int t = 0; t < 6 && !m_pend[5'(ra)]; t++)
            ra = $urandom_range(1, 31);
          if ($urandom_range(0, 9) == 0) ra = 0;
          post(i, ra, $urandom);
        end
      run_wb(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
